// File: rtl/stage_memory_mc.sv
// Multi-cycle memory stage: issues data-memory accesses over a req/ack handshake,
// stalls upstream while an access is outstanding and registers the M/W result.
module stage_memory_mc #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 12,
    parameter logic [4:0]  OP_SW   = 5'b00111,
    parameter logic [4:0]  OP_LW   = 5'b01000,
    parameter int          TIMEOUT = 256,
    parameter int          CNT_W   = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [31:0]       insn_in,
    input  logic [DATA_W-1:0] o_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              wm_bypass,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              valid_out,
    output logic [31:0]       insn_out,
    output logic [DATA_W-1:0] o_out,
    output logic [DATA_W-1:0] d_out,
    output logic              timeout_err
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   counter;
    logic [31:0]        hold_insn;
    logic [DATA_W-1:0]  hold_o;
    logic [4:0]         opcode;
    logic               is_mem;
    logic               timeout_hit;

    assign opcode      = insn_in[31:27];
    assign is_mem      = valid_in && (opcode == OP_LW || opcode == OP_SW);
    assign timeout_hit = (TIMEOUT != 0) && (state == REQ) && !mem_ack && (counter == TO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (is_mem) state_next = REQ;
            REQ:  if (mem_ack || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gated by reset so an async reset drops stall even while a mem op is still presented.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = is_mem;
                REQ:     stall = !mem_ack && !timeout_hit;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            valid_out   <= 1'b0;
            insn_out    <= '0;
            o_out       <= '0;
            d_out       <= '0;
            timeout_err <= 1'b0;
            counter     <= '0;
            hold_insn   <= '0;
            hold_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OP_SW);
                        mem_addr  <= o_in[ADDR_W-1:0];
                        mem_wdata <= wm_bypass ? data_writeReg : b_in;
                        hold_insn <= insn_in;
                        hold_o    <= o_in;
                        counter   <= '0;
                        valid_out <= 1'b0;
                    end else if (valid_in) begin
                        valid_out <= 1'b1;
                        insn_out  <= insn_in;
                        o_out     <= o_in;
                        d_out     <= '0;
                    end else begin
                        valid_out <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        valid_out <= 1'b1;
                        insn_out  <= hold_insn;
                        o_out     <= hold_o;
                        d_out     <= mem_we ? '0 : mem_rdata;
                    end else if (timeout_hit) begin
                        mem_req     <= 1'b0;
                        valid_out   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        counter   <= counter + 1'b1;
                        valid_out <= 1'b0;
                    end
                end
                default: valid_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory_mc.sv
// Self-checking bench for stage_memory_mc: vector table of ALU/load/store ops with a
// scoreboard on the M/W register, plus timeout and async-reset sequences.
module tb_stage_memory_mc;

    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    logic        clock, reset, valid_in, wm_bypass, mem_ack;
    logic [31:0] insn_in, o_in, b_in, data_writeReg, mem_rdata;
    logic        mem_req, mem_we, stall, valid_out, timeout_err;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, insn_out, o_out, d_out;

    stage_memory_mc #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .insn_in(insn_in),
        .o_in(o_in), .b_in(b_in), .wm_bypass(wm_bypass), .data_writeReg(data_writeReg),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .valid_out(valid_out),
        .insn_out(insn_out), .o_out(o_out), .d_out(d_out), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] o;
        logic [31:0] b;
        logic        byp;
        logic [31:0] wdr;
        int          delay;
        logic [31:0] rdata;
        logic [11:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_d;
    } vec_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] o;
        logic [31:0] d;
    } mw_t;

    mw_t  exp_q[$];
    vec_t vecs[7];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every valid_out must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && valid_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid_out", 32'(valid_out), 32'd0);
            end else begin
                mw_t e;
                e = exp_q.pop_front();
                check("mw_insn", insn_out, e.insn);
                check("mw_o", o_out, e.o);
                check("mw_d", d_out, e.d);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the op's completing edge.
    task automatic run_op(input vec_t v, input logic [31:0] insn);
        int  stalls;
        mw_t e;
        valid_in = 1'b1; insn_in = insn; o_in = v.o; b_in = v.b;
        wm_bypass = v.byp; data_writeReg = v.wdr; mem_ack = 1'b0;
        #1;
        if (v.op != OP_LW && v.op != OP_SW) begin
            check("alu_stall", 32'(stall), 32'd0);
            e = '{insn: insn, o: v.o, d: 32'd0};
            exp_q.push_back(e);
            @(posedge clock); #1;
            check("alu_valid_out", 32'(valid_out), 32'd1);
            return;
        end
        stalls = stall ? 1 : 0;
        @(posedge clock); #1;
        check("issue_req", 32'(mem_req), 32'd1);
        check("issue_addr", 32'(mem_addr), 32'(v.exp_addr));
        check("issue_we", 32'(mem_we), 32'(v.exp_we));
        check("issue_wdata", mem_wdata, v.exp_wdata);
        for (int k = 0; k < v.delay; k++) begin
            if (stall) stalls++;
            wm_bypass = ~v.byp; data_writeReg = 32'h77;
            @(posedge clock); #1;
            check("req_valid_out", 32'(valid_out), 32'd0);
        end
        check("hold_wdata", mem_wdata, v.exp_wdata);
        check("hold_addr", 32'(mem_addr), 32'(v.exp_addr));
        check("stall_cycles", 32'(stalls), 32'(1 + v.delay));
        mem_ack = 1'b1; mem_rdata = v.rdata;
        #1;
        check("ack_stall", 32'(stall), 32'd0);
        e = '{insn: insn, o: v.o, d: v.exp_d};
        exp_q.push_back(e);
        @(posedge clock); #1;
        mem_ack = 1'b0;
        check("done_req", 32'(mem_req), 32'd0);
        check("done_valid_out", 32'(valid_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid_in = 1'b0; insn_in = '0; o_in = '0; b_in = '0;
        wm_bypass = 1'b0; data_writeReg = '0; mem_rdata = '0; mem_ack = 1'b0;

        //           op     o             b             byp wdr          dly rdata         addr    we  wdata         d
        vecs[0] = '{5'b00000, 32'h55,       32'h0,        0, 32'h0,        0, 32'h0,        12'h055, 0, 32'h0,        32'h0};
        vecs[1] = '{OP_LW,    32'h1234,     32'h0,        0, 32'h0,        2, 32'hDEADBEEF, 12'h234, 0, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{OP_SW,    32'h0FF0,     32'h11,       1, 32'h99,       2, 32'h5555AAAA, 12'hFF0, 1, 32'h99,       32'h0};
        vecs[3] = '{OP_LW,    32'h40,       32'h3,        0, 32'h99,       0, 32'h12345678, 12'h040, 0, 32'h3,        32'h12345678};
        vecs[4] = '{OP_SW,    32'h44,       32'hCAFEF00D, 0, 32'h99,       0, 32'hFFFFFFFF, 12'h044, 1, 32'hCAFEF00D, 32'h0};
        vecs[5] = '{5'b00001, 32'hFFFFFFFF, 32'h0,        0, 32'h0,        0, 32'h0,        12'hFFF, 0, 32'h0,        32'h0};
        vecs[6] = '{OP_LW,    32'hABCDEF0,  32'h66,       1, 32'h99,       1, 32'hA5A5A5A5, 12'hEF0, 0, 32'h99,       32'hA5A5A5A5};

        #3;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_o_out", o_out, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i], {vecs[i].op, 27'(i * 3 + 1)});
        valid_in = 1'b0;
        @(posedge clock); #1;
        check("bubble_valid_out", 32'(valid_out), 32'd0);

        // Timeout: lw with no ack aborts on the 4th REQ cycle.
        valid_in = 1'b1; insn_in = {OP_LW, 27'h100}; o_in = 32'h80; mem_ack = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            check("to_stall", 32'(stall), (k < 3) ? 32'd1 : 32'd0);
            check("to_req", 32'(mem_req), 32'd1);
            if (k == 3) valid_in = 1'b0;
            @(posedge clock); #1;
        end
        check("to_mem_req", 32'(mem_req), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_valid_out", 32'(valid_out), 32'd0);
        check("to_stall_after", 32'(stall), 32'd0);

        run_op(vecs[0], {5'b00000, 27'h200});
        run_op(vecs[4], {OP_SW, 27'h201});
        valid_in = 1'b0;
        check("err_sticky", 32'(timeout_err), 32'd1);

        // Async reset in the middle of an outstanding load.
        valid_in = 1'b1; insn_in = {OP_LW, 27'h300}; o_in = 32'h90;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_valid_out", 32'(valid_out), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        valid_in = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            check("late_ack_valid_out", 32'(valid_out), 32'd0);
            check("late_ack_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        @(posedge clock); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/stage_memory_mc.md
Name: stage_memory_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle memory stage of the 5-stage pipeline.
- Talks to data memory over a req/ack handshake so variable-latency memory is supported. Raises stall to freeze upstream stages while an access is outstanding.
- Captures the store operand with WM bypass at issue time.
- Registers the stage result as the MEM/WB pipeline register, with a valid bit and a sticky timeout error.

Parameters:
DATA_W, 32, datapath width of o_in/b_in/data_writeReg/mem data
ADDR_W, 12, data-memory address width; address = o_in[ADDR_W-1:0]
OP_SW, 5'b00111, store opcode (insn[31:27])
OP_LW, 5'b01000, load opcode
TIMEOUT, 256, max REQ cycles before abort; 0 disables timeout
CNT_W, 9, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  insn_in/o_in/b_in hold a live instruction
insn_in  in  32  instruction from X/M register
o_in  in  DATA_W  ALU result / effective address
b_in  in  DATA_W  store data from X/M register
wm_bypass  in  1  select data_writeReg as store data
data_writeReg  in  DATA_W  writeback-stage data for WM bypass
mem_rdata  in  DATA_W  load data, valid when mem_ack=1
mem_ack  in  1  memory completes the current request this cycle
mem_req  out  1  access request, registered
mem_we  out  1  1 = store, registered
mem_addr  out  ADDR_W  registered access address
mem_wdata  out  DATA_W  registered store data
stall  out  1  freeze PC, F/D, D/X and X/M registers (combinational)
valid_out  out  1  M/W register valid
insn_out  out  32  M/W instruction
o_out  out  DATA_W  M/W ALU result
d_out  out  DATA_W  M/W load data (0 for non-loads)
timeout_err  out  1  sticky: an access was aborted by timeout

Behaviour:
- Reset (async, any state, mid-access included): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, valid_out, insn_out, o_out, d_out, timeout_err and the counter all go to 0. An outstanding request is dropped; a late mem_ack after reset is ignored.
- is_mem = valid_in & (opcode==OP_LW | opcode==OP_SW). Any other opcode is non-mem.
- State IDLE:
  - valid_in & !is_mem: M/W register loads insn_in, o_in, d_out=0, valid_out=1. stall=0. One-cycle latency.
  - !valid_in: valid_out<=0 (bubble).
  - is_mem: stall=1. Issue the request: mem_req<=1, mem_we<=(opcode==OP_SW), mem_addr<=o_in[ADDR_W-1:0], mem_wdata<=wm_bypass?data_writeReg:b_in. Latch insn_in/o_in into a holding register, counter<=0, valid_out<=0, go to REQ.
- State REQ (mem_req=1):
  - mem_ack=0: stall=1, counter++, valid_out<=0.
  - mem_ack=1: stall=0. M/W loads held insn/o, d_out<=mem_rdata for loads or 0 for stores, valid_out=1. mem_req<=0, go to IDLE.
  - Timeout: TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ack=0. Complete as a bubble: valid_out<=0, mem_req<=0, timeout_err<=1, stall=0, go to IDLE.
  - mem_ack and timeout in the same cycle: ack wins; timeout_err is unchanged.
- Minimum mem-op latency is 2 cycles (IDLE issue + REQ with immediate ack). stall is high for exactly the cycles before the ack cycle.
- mem_ack while in IDLE is ignored.
- Store data is sampled only at issue. Later changes to wm_bypass or data_writeReg during REQ do not alter mem_wdata.
- mem_addr/mem_we/mem_wdata hold stable throughout REQ.
- Upstream contract: while stall=1, insn_in/o_in/b_in/valid_in are held. The cycle after the ack the next instruction is presented, so back-to-back mem ops issue with no extra bubble beyond the IDLE cycle.
- timeout_err clears only on reset.

Test Plan:
- ALU op: valid_in=1, opcode 00000, o_in=0x55 -> next edge valid_out=1, o_out=0x55, d_out=0, stall never high.
- Load, 3-cycle ack: lw, o_in=0x1234 -> mem_addr=0x234, mem_we=0, stall high 3 cycles. Ack with mem_rdata=0xDEADBEEF -> next edge d_out=0xDEADBEEF, valid_out=1; mem_req low.
- Store with bypass: sw, b_in=0x11, wm_bypass=1, data_writeReg=0x99 -> mem_wdata=0x99, mem_we=1. Change data_writeReg to 0x77 during REQ -> mem_wdata stays 0x99. Ack -> d_out=0.
- Back-to-back: lw then sw, immediate acks -> each takes 2 cycles, valid_out pulses once per instruction, no lost or duplicated instruction.
- Timeout: TIMEOUT=4, lw with no ack -> after 4 REQ cycles mem_req=0, stall=0, timeout_err=1, valid_out=0. timeout_err stays 1 across later ops until reset.
- Async reset mid-REQ -> mem_req, valid_out and stall fall immediately without a clock edge. Post-reset mem_ack pulse -> no valid_out.
